// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART command path: the frame sync byte, the
// command opcodes carried in ADDR[7:6], the receive FSM states and the
// frame checksum helper.
package uart_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        OP_COMPARE,
        OP_DIV,
        OP_ENABLE,
        OP_RSVD
    } pwm_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GOT_SYNC,
        ST_GOT_ADDR,
        ST_GOT_DATA
    } frame_state_t;

    function automatic logic [7:0] frame_chk(input logic [7:0] addr, input logic [7:0] data);
        return addr ^ data;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// frame_timer
// Inter-byte idle timer. Counts up while enabled and raises a combinational
// expire flag in the cycle the count sits at TIMEOUT_CYCLES-1. Clear has
// priority over counting.
// Ports:
//   clk      system clock
//   reset    synchronous, active-high reset
//   clr      force the count back to zero
//   en       count this cycle
//   expired  high while enabled with the count at its terminal value
module frame_timer #(
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

    assign expired = en && (cnt == LAST);

endmodule

// File: rtl/uart_pwm_cmd_ctrl.sv
// uart_pwm_cmd_ctrl
// Assembles UART bytes into SYNC/ADDR/DATA/CHK frames, validates them and
// applies them to the PWM configuration registers it owns.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   rx_valid, rx_data   received byte strobe and value
//   rx_err              framing/parity error strobe for the current byte
//   enable_o            per-channel PWM enable mask
//   compare_o, div_o    packed per-channel compare / divider values
//   cmd_ok, cmd_err     one-cycle frame accepted / aborted pulses
//   busy_o              frame reception in progress
//
// state        | meaning
// -------------+---------------------------------------------
// ST_IDLE      | hunting for SYNC_BYTE, other bytes dropped
// ST_GOT_SYNC  | sync seen, next byte is ADDR (no resync)
// ST_GOT_ADDR  | ADDR latched, next byte is DATA
// ST_GOT_DATA  | DATA latched, next byte is CHK -> check/commit
module uart_pwm_cmd_ctrl
    import uart_pkg::*;
#(
    parameter int                    NUM_CH         = 8,
    parameter int                    PWM_BITS       = 8,
    parameter int                    DIV_WIDTH      = 8,
    parameter logic [PWM_BITS-1:0]   DEF_COMPARE    = 8'd25,
    parameter logic [DIV_WIDTH-1:0]  DEF_DIV        = 8'd100,
    parameter int                    TIMEOUT_CYCLES = 500000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx_valid,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_err,
    output logic [NUM_CH-1:0]             enable_o,
    output logic [NUM_CH*PWM_BITS-1:0]    compare_o,
    output logic [NUM_CH*DIV_WIDTH-1:0]   div_o,
    output logic                          cmd_ok,
    output logic                          cmd_err,
    output logic                          busy_o
);

    localparam logic [3:0] NUM_CH_L = 4'(NUM_CH);

    frame_state_t state_q, state_d;
    logic [7:0]   addr_q, data_q;
    logic         lat_addr, lat_data;
    logic         ok_d, err_d;
    logic         wr_cmp, wr_div, wr_en;
    logic         byte_ok;
    logic         tmr_expired;
    logic         chk_ok, ch_ok;
    pwm_op_t      op;
    logic [2:0]   ch;

    logic [PWM_BITS-1:0]  compare_q [NUM_CH];
    logic [DIV_WIDTH-1:0] div_q     [NUM_CH];
    logic [NUM_CH-1:0]    enable_q;

    // A byte flagged with rx_err is never treated as received.
    assign byte_ok = rx_valid && !rx_err;

    assign op     = pwm_op_t'(addr_q[7:6]);
    assign ch     = addr_q[2:0];
    assign ch_ok  = {1'b0, ch} < NUM_CH_L;
    assign chk_ok = (rx_data == frame_chk(addr_q, data_q));

    frame_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (byte_ok || (state_d == ST_IDLE)),
        .en      (state_q != ST_IDLE),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            busy_o  <= 1'b0;
            cmd_ok  <= 1'b0;
            cmd_err <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            busy_o  <= (state_d != ST_IDLE);
            cmd_ok  <= ok_d;
            cmd_err <= err_d;
            if (lat_addr) addr_q <= rx_data;
            if (lat_data) data_q <= rx_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        lat_addr = 1'b0;
        lat_data = 1'b0;
        ok_d     = 1'b0;
        err_d    = 1'b0;
        wr_cmp   = 1'b0;
        wr_div   = 1'b0;
        wr_en    = 1'b0;
        if (state_q == ST_IDLE) begin
            if (byte_ok && (rx_data == SYNC_BYTE)) state_d = ST_GOT_SYNC;
        end else if (rx_err) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end else if (rx_valid) begin
            // A byte arriving in the expire cycle takes precedence.
            case (state_q)
                ST_GOT_SYNC: begin
                    lat_addr = 1'b1;
                    state_d  = ST_GOT_ADDR;
                end
                ST_GOT_ADDR: begin
                    lat_data = 1'b1;
                    state_d  = ST_GOT_DATA;
                end
                default: begin
                    state_d = ST_IDLE;
                    if (!chk_ok) begin
                        err_d = 1'b1;
                    end else begin
                        case (op)
                            OP_COMPARE: begin
                                wr_cmp = ch_ok;
                                ok_d   = ch_ok;
                                err_d  = !ch_ok;
                            end
                            OP_DIV: begin
                                wr_div = ch_ok;
                                ok_d   = ch_ok;
                                err_d  = !ch_ok;
                            end
                            OP_ENABLE: begin
                                wr_en = 1'b1;
                                ok_d  = 1'b1;
                            end
                            default: err_d = 1'b1;
                        endcase
                    end
                end
            endcase
        end else if (tmr_expired) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end
    end

    // Register bank: written from the latched ADDR/DATA on the CHK edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            enable_q <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                compare_q[c] <= DEF_COMPARE;
                div_q[c]     <= DEF_DIV;
            end
        end else begin
            if (wr_en) enable_q <= data_q[NUM_CH-1:0];
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_cmp && (ch == c[2:0])) compare_q[c] <= data_q[PWM_BITS-1:0];
                if (wr_div && (ch == c[2:0])) div_q[c]     <= data_q[DIV_WIDTH-1:0];
            end
        end
    end

    assign enable_o = enable_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
        assign compare_o[g*PWM_BITS +: PWM_BITS]  = compare_q[g];
        assign div_o[g*DIV_WIDTH +: DIV_WIDTH]    = div_q[g];
    end

endmodule

// File: doc/uart_pwm_cmd_ctrl.md
Name: uart_pwm_cmd_ctrl

Overview:
Command controller between the UART receiver and the PWM channel bank. It assembles received bytes into fixed 4-byte frames and checks each frame. A valid frame writes the per-channel compare value, the per-channel divider, or the global enable mask. It owns all PWM configuration state, so top level drives every pwm instance from this block rather than from constants or raw rx data.

Parameters:
NUM_CH, 8, number of PWM channels (1..8, addressed by a 3-bit channel field)
PWM_BITS, 8, width of each compare register
DIV_WIDTH, 8, width of each divider register
DEF_COMPARE, 8'd25, reset value of every compare register
DEF_DIV, 8'd100, reset value of every divider register
TIMEOUT_CYCLES, 500000, maximum idle gap between bytes of one frame (10 ms at 50 MHz)

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high reset
rx_valid  in  1  one-cycle strobe: rx_data holds a newly received byte
rx_data  in  8  received byte
rx_err  in  1  one-cycle strobe: framing or parity error on the current byte
enable_o  out  NUM_CH  per-channel PWM enable mask
compare_o  out  NUM_CH*PWM_BITS  packed compare values; channel c occupies [c*PWM_BITS +: PWM_BITS]
div_o  out  NUM_CH*DIV_WIDTH  packed divider values, same packing as compare_o
cmd_ok  out  1  one-cycle pulse: frame accepted and applied
cmd_err  out  1  one-cycle pulse: frame aborted
busy_o  out  1  high whenever the FSM is not in IDLE

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values: enable_o=0, every compare=DEF_COMPARE, every div=DEF_DIV, cmd_ok=0, cmd_err=0, busy_o=0, FSM=IDLE, timer=0.
- Frame format: SYNC(0xA5), ADDR, DATA, CHK.
  - ADDR[7:6] = op: 00 compare, 01 div, 10 enable mask, 11 reserved.
  - ADDR[5:3] are ignored. ADDR[2:0] is the channel.
  - CHK must equal ADDR ^ DATA.
- FSM states: IDLE, GOT_SYNC, GOT_ADDR, GOT_DATA.
  - IDLE: rx_valid with 0xA5 -> GOT_SYNC. Any other byte is silently discarded; no cmd_err.
  - GOT_SYNC: rx_valid latches ADDR -> GOT_ADDR. 0xA5 is latched as ADDR; there is no resync.
  - GOT_ADDR: rx_valid latches DATA -> GOT_DATA.
  - GOT_DATA: rx_valid -> IDLE, then the frame is checked.
- Commit rule:
  - CHK byte arrives in cycle N and the frame is valid: the register write and cmd_ok are both visible in cycle N+1. Latency from the CHK strobe is 1 cycle.
  - op 00: compare[ch] <= DATA[PWM_BITS-1:0].
  - op 01: div[ch] <= DATA[DIV_WIDTH-1:0].
  - op 10: enable_o <= DATA[NUM_CH-1:0]; the channel field is ignored.
- Errors: each of the following pulses cmd_err in N+1, writes nothing, and returns to IDLE:
  - CHK mismatch,
  - op 11,
  - op 00 or 01 with ch >= NUM_CH.
- Timeout:
  - The timer clears on every accepted byte and counts while not in IDLE.
  - When the timer reaches TIMEOUT_CYCLES-1 with no rx_valid: -> IDLE and cmd_err pulses the next cycle.
  - If rx_valid coincides with the timeout cycle, the byte wins and the timer clears.
- rx_err in any non-IDLE state aborts the frame: -> IDLE, cmd_err pulses the next cycle. In IDLE, rx_err is ignored.
  - rx_err in the same cycle as rx_valid: the error wins and the byte is dropped.
- cmd_ok and cmd_err are never high together.
- Reset mid-frame discards the partial frame. Reset also restores the default registers, so PWM outputs revert the cycle after reset.
- busy_o is a registered decode of the state (not IDLE).

Decomposition:
- Add to uart_pkg:
  - SYNC_BYTE = 8'hA5,
  - typedef enum logic [1:0] {OP_COMPARE, OP_DIV, OP_ENABLE, OP_RSVD} pwm_op_t,
  - typedef enum for the FSM states.
- Sub-module frame_timer (down/up counter with clear, enable and expire pulse, parameter TIMEOUT_CYCLES). It is reused later by the TX response path.
- The register bank stays inline.

Test Plan:
- Reset, then inspect outputs -> enable_o=8'h00, every compare=25, every div=100, busy_o=0.
- Bytes A5,03,80,83 -> compare[3]=0x80 in the cycle after the CHK strobe, cmd_ok for 1 cycle, other channels unchanged.
- Bytes A5,80,F0,70 -> enable_o=8'hF0 and cmd_ok. Then A5,45,0A,4F -> div[5]=10.
- Bytes A5,03,80,84 (bad CHK) -> cmd_err pulse, compare[3] unchanged. Then 11,22,A5,02,40,42 -> leading 11,22 discarded, compare[2]=0x40 and cmd_ok.
- Bytes A5,03 then idle for TIMEOUT_CYCLES (set to 100 for this test) -> cmd_err at cycle 100, busy_o low. A following A5,03,80,83 is accepted normally.
- rx_err strobe after A5,01 -> cmd_err and return to IDLE. Separately, assert reset after A5,01,FF -> all defaults restored and no cmd_ok or cmd_err pulse.
